// File: rtl/robo_ambiente.sv
// Plant model for the wall-following controller: robot pose, timed move/turn FSM
// and a bit-per-cell wall map. head/left are combinational wall lookups around the robot.
module robo_ambiente #(
    parameter int GRID_W      = 8,
    parameter int GRID_H      = 8,
    parameter int CW          = 3,
    parameter int X0          = 0,
    parameter int Y0          = 0,
    parameter int DIR0        = 0,
    parameter int MOVE_CYCLES = 4,
    parameter int TURN_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          avancar,
    input  logic          girar,
    input  logic          mapa_we,
    input  logic [CW-1:0] mapa_x,
    input  logic [CW-1:0] mapa_y,
    input  logic          mapa_din,
    output logic          head,
    output logic          left,
    output logic [CW-1:0] pos_x,
    output logic [CW-1:0] pos_y,
    output logic [1:0]    direcao,
    output logic          ocupado,
    output logic          colisao,
    output logic          erro,
    output logic [15:0]   passos
);

    typedef enum logic [1:0] {
        PARADO,
        MOVENDO,
        GIRANDO
    } state_t;

    localparam int            CELLS = GRID_W * GRID_H;
    localparam int            IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [CW:0]   LP_W  = (CW+1)'(GRID_W);
    localparam logic [CW:0]   LP_H  = (CW+1)'(GRID_H);

    state_t           r_state;
    logic [15:0]      r_cnt;
    logic [CW-1:0]    r_x;
    logic [CW-1:0]    r_y;
    logic [1:0]       r_dir;
    logic [CW-1:0]    r_dest_x;
    logic [CW-1:0]    r_dest_y;
    logic [CELLS-1:0] r_mapa;
    logic             r_ocupado;
    logic             r_colisao;
    logic             r_erro;
    logic [15:0]      r_passos;

    logic [2*CW+1:0]  w_ahead;
    logic [2*CW+1:0]  w_side;
    logic             w_map_ok;
    logic [IW-1:0]    w_map_idx;

    // One-cell step in CW+1 bits: stepping off either edge lands on a value >= grid size.
    function automatic logic [2*CW+1:0] f_step(input logic [CW:0] x, input logic [CW:0] y,
                                               input logic [1:0] d);
        logic [CW:0] nx;
        logic [CW:0] ny;
        nx = x;
        ny = y;
        case (d)
            2'd0:    ny = y + 1'b1;
            2'd1:    nx = x + 1'b1;
            2'd2:    ny = y - 1'b1;
            default: nx = x - 1'b1;
        endcase
        return {nx, ny};
    endfunction

    function automatic logic f_wall(input logic [CELLS-1:0] m, input logic [CW:0] x,
                                    input logic [CW:0] y);
        logic [IW-1:0] idx;
        if (x >= LP_W || y >= LP_H) return 1'b1;
        idx = IW'(int'(y) * GRID_W + int'(x));
        return m[idx];
    endfunction

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        w_ahead   = f_step({1'b0, r_x}, {1'b0, r_y}, r_dir);
        w_side    = f_step({1'b0, r_x}, {1'b0, r_y}, r_dir - 2'd1);
        head      = f_wall(r_mapa, w_ahead[2*CW+1:CW+1], w_ahead[CW:0]);
        left      = f_wall(r_mapa, w_side[2*CW+1:CW+1], w_side[CW:0]);
        w_map_idx = IW'(int'(mapa_y) * GRID_W + int'(mapa_x));
        w_map_ok  = mapa_we
                 && ({1'b0, mapa_x} < LP_W) && ({1'b0, mapa_y} < LP_H)
                 && !(mapa_x == r_x && mapa_y == r_y)
                 && !(r_state == MOVENDO && mapa_x == r_dest_x && mapa_y == r_dest_y);
    end

    // NOTE: the wall map is a flop array, not RAM, so it can and must clear on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mapa <= '0;
        end else if (w_map_ok) begin
            r_mapa[w_map_idx] <= mapa_din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= PARADO;
            r_cnt     <= '0;
            r_x       <= CW'(X0);
            r_y       <= CW'(Y0);
            r_dir     <= 2'(DIR0);
            r_dest_x  <= CW'(X0);
            r_dest_y  <= CW'(Y0);
            r_ocupado <= 1'b0;
            r_colisao <= 1'b0;
            r_erro    <= 1'b0;
            r_passos  <= '0;
        end else begin
            r_colisao <= 1'b0;
            case (r_state)
                PARADO: begin
                    if (avancar && girar) begin
                        r_erro <= 1'b1;
                    end else if (avancar) begin
                        if (head) begin
                            r_colisao <= 1'b1;
                        end else begin
                            r_state   <= MOVENDO;
                            r_cnt     <= 16'(MOVE_CYCLES - 1);
                            r_dest_x  <= w_ahead[2*CW:CW+1];
                            r_dest_y  <= w_ahead[CW-1:0];
                            r_ocupado <= 1'b1;
                        end
                    end else if (girar) begin
                        r_state   <= GIRANDO;
                        r_cnt     <= 16'(TURN_CYCLES - 1);
                        r_ocupado <= 1'b1;
                    end
                end
                MOVENDO: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        r_x       <= r_dest_x;
                        r_y       <= r_dest_y;
                        r_state   <= PARADO;
                        r_ocupado <= 1'b0;
                        if (r_passos != 16'hFFFF) r_passos <= r_passos + 16'd1;
                    end
                end
                GIRANDO: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        r_dir     <= r_dir + 2'd1;
                        r_state   <= PARADO;
                        r_ocupado <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= PARADO;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign pos_x   = r_x;
    assign pos_y   = r_y;
    assign direcao = r_dir;
    assign ocupado = r_ocupado;
    assign colisao = r_colisao;
    assign erro    = r_erro;
    assign passos  = r_passos;

endmodule

// File: tb/tb_robo_ambiente.sv
// Directed bench for robo_ambiente: a cycle-level world model drives a per-cycle compare,
// and literal checks pin the scenario outcomes.
module tb_robo_ambiente;

    logic        clock = 1'b0;
    logic        reset;
    logic        avancar;
    logic        girar;
    logic        mapa_we;
    logic [2:0]  mapa_x;
    logic [2:0]  mapa_y;
    logic        mapa_din;
    logic        head;
    logic        left;
    logic [2:0]  pos_x;
    logic [2:0]  pos_y;
    logic [1:0]  direcao;
    logic        ocupado;
    logic        colisao;
    logic        erro;
    logic [15:0] passos;

    int n_pass  = 0;
    int n_total = 0;

    robo_ambiente dut (
        .clock(clock), .reset(reset), .avancar(avancar), .girar(girar),
        .mapa_we(mapa_we), .mapa_x(mapa_x), .mapa_y(mapa_y), .mapa_din(mapa_din),
        .head(head), .left(left), .pos_x(pos_x), .pos_y(pos_y), .direcao(direcao),
        .ocupado(ocupado), .colisao(colisao), .erro(erro), .passos(passos)
    );

    always #5 clock = ~clock;

    // World model: pose, remaining busy edges, pending destination, wall grid.
    int m_x, m_y, m_dir, m_busy, m_dx, m_dy, m_steps;
    bit m_move, m_col, m_err, m_chk;
    bit m_map[8][8];

    function automatic int sx(int d);
        return (d == 1) ? 1 : (d == 3) ? -1 : 0;
    endfunction

    function automatic int sy(int d);
        return (d == 0) ? 1 : (d == 2) ? -1 : 0;
    endfunction

    function automatic bit m_wall(int x, int y);
        if (x < 0 || x > 7 || y < 0 || y > 7) return 1'b1;
        return m_map[x][y];
    endfunction

    task automatic m_reset();
        m_x = 0; m_y = 0; m_dir = 0; m_busy = 0; m_dx = 0; m_dy = 0; m_steps = 0;
        m_move = 0; m_col = 0; m_err = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                m_map[i][j] = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    initial begin : model_proc
        bit wr;
        forever begin
            @(posedge clock);
            if (reset) begin
                wr = mapa_we && !(mapa_x == m_x && mapa_y == m_y)
                     && !(m_busy > 0 && m_move && mapa_x == m_dx && mapa_y == m_dy);
                m_col = 1'b0;
                if (m_busy > 0) begin
                    m_busy--;
                    if (m_busy == 0) begin
                        if (m_move) begin
                            m_x = m_dx;
                            m_y = m_dy;
                            if (m_steps < 65535) m_steps++;
                        end else begin
                            m_dir = (m_dir + 1) % 4;
                        end
                    end
                end else if (avancar && girar) begin
                    m_err = 1'b1;
                end else if (avancar) begin
                    if (m_wall(m_x + sx(m_dir), m_y + sy(m_dir))) begin
                        m_col = 1'b1;
                    end else begin
                        m_dx = m_x + sx(m_dir);
                        m_dy = m_y + sy(m_dir);
                        m_move = 1'b1;
                        m_busy = 4;
                    end
                end else if (girar) begin
                    m_move = 1'b0;
                    m_busy = 2;
                end
                if (wr) m_map[mapa_x][mapa_y] = mapa_din;
            end
        end
    end

    initial begin : compare_proc
        forever begin
            @(negedge clock);
            if (m_chk) begin
                check("pos_x", pos_x, m_x);
                check("pos_y", pos_y, m_y);
                check("direcao", direcao, m_dir);
                check("ocupado", ocupado, (m_busy > 0) ? 1 : 0);
                check("colisao", colisao, m_col);
                check("erro", erro, m_err);
                check("passos", passos, m_steps);
                check("head", head, m_wall(m_x + sx(m_dir), m_y + sy(m_dir)));
                check("left", left, m_wall(m_x + sx((m_dir + 3) % 4), m_y + sy((m_dir + 3) % 4)));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ocupado && n < 20) begin
            step();
            n++;
        end
        check("idle_timeout", ocupado, 0);
    endtask

    task automatic adv();
        avancar = 1'b1;
        step();
        avancar = 1'b0;
        wait_idle();
    endtask

    task automatic trn();
        girar = 1'b1;
        step();
        girar = 1'b0;
        wait_idle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_chk = 1'b0;
        m_reset();
        step();
        step();
        reset = 1'b1;
        m_chk = 1'b1;
    endtask

    task automatic map_write(input int x, input int y, input bit v);
        mapa_we  = 1'b1;
        mapa_x   = 3'(x);
        mapa_y   = 3'(y);
        mapa_din = v;
        step();
        mapa_we  = 1'b0;
    endtask

    int exp_dir[4] = '{1, 2, 3, 0};

    initial begin
        reset = 1'b0; avancar = 1'b0; girar = 1'b0;
        mapa_we = 1'b0; mapa_x = '0; mapa_y = '0; mapa_din = 1'b0;
        m_chk = 1'b0;
        m_reset();
        do_reset();
        check("rst_pos_x", pos_x, 0);
        check("rst_pos_y", pos_y, 0);
        check("rst_dir", direcao, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_passos", passos, 0);
        check("rst_erro", erro, 0);

        // Single advance: busy for four cycles, then one cell north
        avancar = 1'b1;
        step();
        avancar = 1'b0;
        check("t1_busy_first", ocupado, 1);
        repeat (3) step();
        check("t1_busy_last", ocupado, 1);
        check("t1_pos_hold", pos_y, 0);
        step();
        check("t1_done", ocupado, 0);
        check("t1_pos_y", pos_y, 1);
        check("t1_passos", passos, 1);

        // Run to the north border and bump into it
        repeat (6) adv();
        check("t2_pos_y", pos_y, 7);
        check("t2_head", head, 1);
        avancar = 1'b1;
        step();
        avancar = 1'b0;
        check("t2_colisao", colisao, 1);
        check("t2_no_busy", ocupado, 0);
        step();
        check("t2_colisao_end", colisao, 0);
        check("t2_pos_y_kept", pos_y, 7);
        check("t2_passos_kept", passos, 7);

        // Return to (0,0) facing N, then four timed turns
        trn(); trn();
        repeat (7) adv();
        trn(); trn();
        check("t3_pos_y", pos_y, 0);
        check("t3_left", left, 1);
        check("t3_passos", passos, 14);
        for (int k = 0; k < 4; k++) begin
            girar = 1'b1;
            step();
            girar = 1'b0;
            step();
            check("t3_turn_busy", ocupado, 1);
            step();
            check("t3_dir", direcao, exp_dir[k]);
            check("t3_turn_done", ocupado, 0);
        end
        check("t3_erro", erro, 0);

        // Map writes: wall ahead seen next cycle, write to own cell ignored
        map_write(0, 1, 1'b1);
        check("t4_head_wall", head, 1);
        map_write(0, 0, 1'b1);
        trn();
        adv();
        trn(); trn();
        check("t4_pos_x", pos_x, 1);
        check("t4_dir_w", direcao, 3);
        check("t4_cell00_free", head, 0);

        // Simultaneous commands set sticky erro, no motion
        avancar = 1'b1;
        girar   = 1'b1;
        step();
        avancar = 1'b0;
        girar   = 1'b0;
        check("t5_erro", erro, 1);
        check("t5_no_busy", ocupado, 0);
        repeat (5) step();
        check("t5_erro_sticky", erro, 1);
        check("t5_pos_x", pos_x, 1);
        check("t5_dir", direcao, 3);

        // Reset clears erro and map; reset mid-move aborts immediately
        do_reset();
        check("t6_erro_clr", erro, 0);
        check("t6_map_clr", head, 0);
        avancar = 1'b1;
        step();
        avancar = 1'b0;
        step();
        reset = 1'b0;
        m_chk = 1'b0;
        m_reset();
        #1;
        check("t6_abort_pos_y", pos_y, 0);
        check("t6_abort_pos_x", pos_x, 0);
        check("t6_abort_busy", ocupado, 0);
        check("t6_abort_passos", passos, 0);
        step();
        reset = 1'b1;
        m_chk = 1'b1;
        step();
        adv();
        check("t6_move_after", pos_y, 1);
        check("t6_passos_after", passos, 1);

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
